axis_decimating_averager: RTL

AXIS_DECIMATING_AVERAGER -- requirements
Module: axis_decimating_averager

---
 rtl/axis_decimating_averager_pkg.sv | 19 +
 rtl/axis_decimating_averager_core.sv | 57 +++++
 rtl/axis_decimating_averager.sv | 108 ++++++++++
 3 files changed

// File: rtl/axis_decimating_averager_pkg.sv
// rtl/axis_decimating_averager_pkg.sv - shared config-bus layout and averager state encoding
package axis_decimating_averager_pkg;

  localparam int config_bus_width  = 512;
  localparam int config_k_lsb      = 0;
  localparam int config_k_width    = 32;
  localparam int config_enable_bit = 32;

  typedef enum logic {
    st_disabled   = 1'b0,
    st_accumulate = 1'b1
  } avg_state_t;

  // Requested log2 decimation is clamped so the accumulator can never overflow.
  function automatic logic [31:0] clamp_k(input logic [31:0] k, input int unsigned max_k);
    return (k > max_k) ? 32'(max_k) : k;
  endfunction

endpackage

// File: rtl/axis_decimating_averager_core.sv
// rtl/axis_decimating_averager_core.sv - accumulate, round-half-up and shift datapath
module dec_avg_core
  import axis_decimating_averager_pkg::*;
#(
  parameter int signal_width = 32,
  parameter int max_log2_dec = 12,
  parameter int k_width      = 4
) (
  input  logic                    aclk,
  input  logic                    clear,
  input  logic                    accept,
  input  logic [k_width-1:0]      k,
  input  logic [signal_width-1:0] sample,
  output logic                    done,
  output logic [signal_width-1:0] result
);

  localparam int acc_width = signal_width + max_log2_dec;
  localparam int cnt_width = max_log2_dec + 1;

  logic signed [acc_width-1:0] acc_q;
  logic signed [acc_width-1:0] sum;
  logic signed [acc_width-1:0] half;
  logic signed [acc_width-1:0] rounded;
  logic [cnt_width-1:0]        count_q;
  logic [cnt_width-1:0]        count_inc;
  logic [cnt_width-1:0]        target;
  logic                        unused_rounded;

  assign sum       = acc_q + {{max_log2_dec{sample[signal_width-1]}}, sample};
  assign count_inc = count_q + cnt_width'(1);
  assign target    = cnt_width'(1) << k;
  assign done      = accept && (count_inc == target);

  // The final sample is folded into the sum combinationally so the result is ready at its edge.
  always_comb begin
    half = '0;
    if (k != '0) begin
      half = acc_width'(1) << (k - 1'b1);
    end
    rounded = (sum + half) >>> k;
  end

  assign result         = rounded[signal_width-1:0];
  assign unused_rounded = ^rounded[acc_width-1:signal_width];

  always_ff @(posedge aclk) begin
    if (clear || done) begin
      acc_q   <= '0;
      count_q <= '0;
    end else if (accept) begin
      acc_q   <= sum;
      count_q <= count_inc;
    end
  end

endmodule

// File: rtl/axis_decimating_averager.sv
// rtl/axis_decimating_averager.sv - config-addressed decimating boxcar averager for AXI-Stream samples
module axis_decimating_averager
  import axis_decimating_averager_pkg::*;
#(
  parameter int signal_width          = 32,
  parameter int max_log2_dec          = 12,
  parameter int configuration_address = 1000
) (
  input  logic                        aclk,
  input  logic                        resetn,
  input  logic [31:0]                 config_addr,
  input  logic [config_bus_width-1:0] config_data,
  input  logic [signal_width-1:0]     S_AXIS_in_tdata,
  input  logic                        S_AXIS_in_tvalid,
  output logic [signal_width-1:0]     M_AXIS_out_tdata,
  output logic                        M_AXIS_out_tvalid,
  output logic                        decii_clk,
  output logic [signal_width-1:0]     M_AXIS_pass_tdata,
  output logic                        M_AXIS_pass_tvalid
);

  localparam int k_width = $clog2(max_log2_dec + 1);

  logic                    config_hit;
  logic [31:0]             k_cfg;
  logic [k_width-1:0]      k_q;
  logic                    enable_q;
  avg_state_t              state_q;
  avg_state_t              state_next;
  logic                    accept;
  logic                    done;
  logic [signal_width-1:0] result;
  logic [signal_width-1:0] out_tdata_q;
  logic                    out_tvalid_q;
  logic                    unused_config;

  assign config_hit    = (config_addr == 32'(configuration_address));
  assign k_cfg         = clamp_k(config_data[config_k_lsb +: config_k_width], max_log2_dec);
  assign unused_config = ^{config_data[config_bus_width-1:config_enable_bit+1], k_cfg[31:k_width]};

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      k_q      <= '0;
      enable_q <= 1'b0;
    end else if (config_hit) begin
      k_q      <= k_cfg[k_width-1:0];
      enable_q <= config_data[config_enable_bit];
    end
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state_q <= st_disabled;
    end else begin
      state_q <= state_next;
    end
  end

  // A config match always wins: it blocks accumulation and loads the new enable.
  always_comb begin
    state_next = state_q;
    accept     = 1'b0;
    case (state_q)
      st_disabled:   accept = 1'b0;
      st_accumulate: accept = S_AXIS_in_tvalid;
      default:       accept = 1'b0;
    endcase
    if (config_hit) begin
      accept     = 1'b0;
      state_next = config_data[config_enable_bit] ? st_accumulate : st_disabled;
    end else begin
      state_next = enable_q ? st_accumulate : st_disabled;
    end
  end

  dec_avg_core #(
    .signal_width (signal_width),
    .max_log2_dec (max_log2_dec),
    .k_width      (k_width)
  ) u_core (
    .aclk   (aclk),
    .clear  (!resetn || config_hit),
    .accept (accept),
    .k      (k_q),
    .sample (S_AXIS_in_tdata),
    .done   (done),
    .result (result)
  );

  always_ff @(posedge aclk) begin
    if (!resetn || config_hit) begin
      out_tdata_q  <= '0;
      out_tvalid_q <= 1'b0;
    end else begin
      out_tvalid_q <= done;
      if (done) begin
        out_tdata_q <= result;
      end
    end
  end

  assign M_AXIS_out_tdata   = out_tdata_q;
  assign M_AXIS_out_tvalid  = out_tvalid_q;
  assign decii_clk          = out_tvalid_q;
  assign M_AXIS_pass_tdata  = S_AXIS_in_tdata;
  assign M_AXIS_pass_tvalid = S_AXIS_in_tvalid;

endmodule
